// File: rtl/game_pkg.sv
// Shared definitions for the tic-tac-toe move controller: FSM states,
// checker result codes, ASCII status letters and a one-hot helper.
package game_pkg;

    typedef enum logic [2:0] {
        S_TURN_X = 3'd0,
        S_TURN_O = 3'd1,
        S_COMMIT = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_CATS  = 2'd1,
        RES_WIN_O = 2'd2,
        RES_WIN_X = 2'd3
    } result_t;

    localparam logic [7:0] GS_RUN  = 8'h00;
    localparam logic [7:0] GS_X    = 8'h58;
    localparam logic [7:0] GS_O    = 8'h4F;
    localparam logic [7:0] GS_CATS = 8'h43;
    localparam logic [7:0] GS_ERR  = 8'h45;

    function automatic logic is_one_hot(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

endpackage

// File: rtl/move_check.sv
// Combinational move validator: classifies a button event in a turn state
// as a legal move or an error; with no event neither output is set.
import game_pkg::*;

module move_check (
    input  logic [8:0] sel_pos,
    input  logic [8:0] occ_square,
    input  logic       evX,
    input  logic       evO,
    input  logic       turn_x,
    output logic       legal,
    output logic       error
);

    logic own_ev;
    logic other_ev;
    logic square_ok;

    assign own_ev    = turn_x ? evX : evO;
    assign other_ev  = turn_x ? evO : evX;
    assign square_ok = is_one_hot(sel_pos) && ((sel_pos & occ_square) == 9'd0);

    assign legal = own_ev && !other_ev && square_ok;
    assign error = (own_ev || other_ev) && !legal;

endmodule

// File: rtl/turn_arbiter.sv
// Tic-tac-toe move controller: button edge detect, move arbitration, board write
// strobe and win-checker handshake. Define TURN_TIMEOUT_EN for per-turn forfeit.
import game_pkg::*;

module turn_arbiter #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       buttonX,
    input  logic       buttonO,
    input  logic [8:0] sel_pos,
    input  logic [8:0] occ_square,
    input  logic       chk_valid,
    input  logic [1:0] chk_result,
    output logic       turnX,
    output logic       turnO,
    output logic       wr_en,
    output logic [8:0] wr_pos,
    output logic       wr_player,
    output logic       chk_req,
    output logic [7:0] game_st
);

    state_t     state;
    state_t     next_state;
    logic [7:0] next_game_st;
    logic       buttonX_q;
    logic       buttonO_q;
    logic       armed;
    logic       ev_x;
    logic       ev_o;
    logic       in_turn;
    logic       legal;
    logic       error;
    logic       legal_move;
    logic       error_move;
    logic       expired;

    logic       turnX_d;
    logic       turnO_d;
    logic       wr_en_d;
    logic [8:0] wr_pos_d;
    logic       wr_player_d;
    logic       chk_req_d;

    // armed stays low for the first cycle after reset so a button held
    // through reset release is absorbed into the history register, not seen as an edge
    assign ev_x    = armed && buttonX && !buttonX_q;
    assign ev_o    = armed && buttonO && !buttonO_q;
    assign in_turn = (state == S_TURN_X) || (state == S_TURN_O);

    move_check u_move_check (
        .sel_pos    (sel_pos),
        .occ_square (occ_square),
        .evX        (ev_x),
        .evO        (ev_o),
        .turn_x     (state == S_TURN_X),
        .legal      (legal),
        .error      (error)
    );

    assign legal_move = in_turn && legal;
    assign error_move = in_turn && error;

`ifdef TURN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] turn_cnt;

    assign expired = (turn_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            turn_cnt <= '0;
        end else if ((next_state != state) &&
                     ((next_state == S_TURN_X) || (next_state == S_TURN_O))) begin
            turn_cnt <= '0;
        end else if (in_turn) begin
            turn_cnt <= turn_cnt + 1'b1;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_TURN_X;
            buttonX_q <= 1'b0;
            buttonO_q <= 1'b0;
            armed     <= 1'b0;
        end else begin
            state     <= next_state;
            buttonX_q <= buttonX;
            buttonO_q <= buttonO;
            armed     <= 1'b1;
        end
    end

    // game_st already holds 8'h00 outside DONE/ERR, so holding it by default is enough
    always_comb begin
        next_state   = state;
        next_game_st = game_st;
        case (state)
            S_TURN_X, S_TURN_O: begin
                if (legal_move) begin
                    next_state = S_COMMIT;
                end else if (error_move) begin
                    next_state   = S_ERR;
                    next_game_st = GS_ERR;
                end else if (expired) begin
                    next_state   = S_DONE;
                    next_game_st = (state == S_TURN_X) ? GS_O : GS_X;
                end
            end
            S_COMMIT: next_state = S_CHECK;
            S_CHECK: begin
                if (chk_valid) begin
                    case (chk_result)
                        RES_WIN_X: begin
                            next_state   = S_DONE;
                            next_game_st = GS_X;
                        end
                        RES_WIN_O: begin
                            next_state   = S_DONE;
                            next_game_st = GS_O;
                        end
                        RES_CATS: begin
                            next_state   = S_DONE;
                            next_game_st = GS_CATS;
                        end
                        default: next_state = wr_player ? S_TURN_O : S_TURN_X;
                    endcase
                end
            end
            default: next_state = state;
        endcase
    end

    always_comb begin
        turnX_d     = (next_state == S_TURN_X);
        turnO_d     = (next_state == S_TURN_O);
        wr_en_d     = (next_state == S_COMMIT);
        chk_req_d   = (next_state == S_CHECK);
        wr_pos_d    = wr_pos;
        wr_player_d = wr_player;
        if (legal_move) begin
            wr_pos_d    = sel_pos;
            wr_player_d = (state == S_TURN_X);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            turnX     <= 1'b1;
            turnO     <= 1'b0;
            wr_en     <= 1'b0;
            wr_pos    <= 9'd0;
            wr_player <= 1'b0;
            chk_req   <= 1'b0;
            game_st   <= GS_RUN;
        end else begin
            turnX     <= turnX_d;
            turnO     <= turnO_d;
            wr_en     <= wr_en_d;
            wr_pos    <= wr_pos_d;
            wr_player <= wr_player_d;
            chk_req   <= chk_req_d;
            game_st   <= next_game_st;
        end
    end

endmodule

// File: tb/tb_turn_arbiter.sv
// Self-checking bench for turn_arbiter: a vector table for a full game plus
// short hand-written sequences for error, reset and timeout corner cases.
module tb_turn_arbiter;

    typedef struct {
        logic       tx;
        logic       to;
        logic       we;
        logic [8:0] pos;
        logic       pl;
        logic       cr;
        logic [7:0] gs;
    } exp_t;

    typedef struct {
        logic       bx;
        logic       bo;
        logic [8:0] sel;
        logic [8:0] occ;
        logic       cv;
        logic [1:0] res;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       buttonX;
    logic       buttonO;
    logic [8:0] sel_pos;
    logic [8:0] occ_square;
    logic       chk_valid;
    logic [1:0] chk_result;
    logic       turnX;
    logic       turnO;
    logic       wr_en;
    logic [8:0] wr_pos;
    logic       wr_player;
    logic       chk_req;
    logic [7:0] game_st;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    int    step   = 0;
    string phase  = "init";
    vec_t  tbl[14];

    always #5 clk = ~clk;

    turn_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .buttonX    (buttonX),
        .buttonO    (buttonO),
        .sel_pos    (sel_pos),
        .occ_square (occ_square),
        .chk_valid  (chk_valid),
        .chk_result (chk_result),
        .turnX      (turnX),
        .turnO      (turnO),
        .wr_en      (wr_en),
        .wr_pos     (wr_pos),
        .wr_player  (wr_player),
        .chk_req    (chk_req),
        .game_st    (game_st)
    );

    function automatic exp_t mk(logic tx, logic to, logic we, logic [8:0] pos,
                                logic pl, logic cr, logic [7:0] gs);
        exp_t e;
        e.tx = tx; e.to = to; e.we = we; e.pos = pos; e.pl = pl; e.cr = cr; e.gs = gs;
        return e;
    endfunction

    function automatic exp_t eTX();
        return mk(1, 0, 0, 9'h000, 0, 0, 8'h00);
    endfunction

    function automatic exp_t eTO();
        return mk(0, 1, 0, 9'h000, 0, 0, 8'h00);
    endfunction

    function automatic exp_t eCommit(logic [8:0] pos, logic pl);
        return mk(0, 0, 1, pos, pl, 0, 8'h00);
    endfunction

    function automatic exp_t eCheck();
        return mk(0, 0, 0, 9'h000, 0, 1, 8'h00);
    endfunction

    function automatic exp_t eEnd(logic [7:0] gs);
        return mk(0, 0, 0, 9'h000, 0, 0, gs);
    endfunction

    function automatic vec_t V(logic bx, logic bo, logic [8:0] sel, logic [8:0] occ,
                               logic cv, logic [1:0] res, exp_t e);
        vec_t v;
        v.bx = bx; v.bo = bo; v.sel = sel; v.occ = occ; v.cv = cv; v.res = res; v.e = e;
        return v;
    endfunction

    // wr_pos/wr_player are only meaningful alongside wr_en, so they are masked otherwise
    task automatic checkOutput();
        exp_t        e;
        logic [21:0] act;
        logic [21:0] expv;
        logic [21:0] mask;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s step %0d: scoreboard empty, got %h", phase, step, act);
        end else begin
            e    = sb.pop_front();
            act  = {turnX, turnO, wr_en, wr_pos, wr_player, chk_req, game_st};
            expv = {e.tx, e.to, e.we, e.pos, e.pl, e.cr, e.gs};
            mask = e.we ? 22'h3FFFFF : 22'h3801FF;
            if (((act ^ expv) & mask) != 22'd0) begin
                errors++;
                $display("[TB] FAIL %s step %0d: got {tx,to,we,pos,pl,cr,gs}=%h expected %h (mask %h)",
                         phase, step, act, expv, mask);
            end
        end
        step++;
    endtask

    task automatic applyStimulus(input vec_t v);
        buttonX    = v.bx;
        buttonO    = v.bo;
        sel_pos    = v.sel;
        occ_square = v.occ;
        chk_valid  = v.cv;
        chk_result = v.res;
        sb.push_back(v.e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle(input exp_t e);
        applyStimulus(V(0, 0, 9'h000, 9'h000, 0, 2'd0, e));
    endtask

    task automatic doReset(input string name, input logic hold_x);
        phase      = name;
        step       = 0;
        reset      = 1'b1;
        buttonX    = hold_x;
        buttonO    = 1'b0;
        sel_pos    = 9'h010;
        occ_square = 9'h000;
        chk_valid  = 1'b0;
        chk_result = 2'd0;
        sb.push_back(eTX());
        @(posedge clk);
        #1;
        checkOutput();
        reset = 1'b0;
    endtask

    // X plays sel into an empty board and the checker answers immediately
    task automatic xMoveToCheck(input logic [8:0] sel);
        idle(eTX());
        applyStimulus(V(1, 0, sel, 9'h000, 0, 2'd0, eCommit(sel, 1)));
        applyStimulus(V(0, 0, sel, 9'h000, 0, 2'd0, eCheck()));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tbl[0]  = V(0, 0, 9'h000, 9'h000, 0, 2'd0, eTX());
        tbl[1]  = V(1, 0, 9'h010, 9'h000, 0, 2'd0, eCommit(9'h010, 1));
        tbl[2]  = V(1, 0, 9'h010, 9'h000, 0, 2'd0, eCheck());
        tbl[3]  = V(0, 0, 9'h000, 9'h010, 0, 2'd0, eCheck());
        tbl[4]  = V(0, 0, 9'h000, 9'h010, 0, 2'd0, eCheck());
        tbl[5]  = V(0, 0, 9'h000, 9'h010, 1, 2'd0, eTO());
        tbl[6]  = V(0, 1, 9'h001, 9'h010, 0, 2'd0, eCommit(9'h001, 0));
        tbl[7]  = V(0, 0, 9'h001, 9'h011, 0, 2'd0, eCheck());
        tbl[8]  = V(0, 0, 9'h000, 9'h011, 1, 2'd0, eTX());
        tbl[9]  = V(1, 0, 9'h100, 9'h011, 0, 2'd0, eCommit(9'h100, 1));
        tbl[10] = V(0, 0, 9'h000, 9'h111, 1, 2'd0, eCheck());
        tbl[11] = V(0, 0, 9'h000, 9'h111, 1, 2'd3, eEnd(8'h58));
        tbl[12] = V(1, 0, 9'h001, 9'h000, 0, 2'd0, eEnd(8'h58));
        tbl[13] = V(0, 0, 9'h000, 9'h000, 0, 2'd0, eEnd(8'h58));

        doReset("game_table", 0);
        for (int i = 0; i < 14; i++) applyStimulus(tbl[i]);

        doReset("wrong_player", 0);
        idle(eTX());
        applyStimulus(V(0, 1, 9'h010, 9'h000, 0, 2'd0, eEnd(8'h45)));
        idle(eEnd(8'h45));
        applyStimulus(V(1, 0, 9'h010, 9'h000, 0, 2'd0, eEnd(8'h45)));

        doReset("both_buttons", 0);
        idle(eTX());
        applyStimulus(V(1, 1, 9'h010, 9'h000, 0, 2'd0, eEnd(8'h45)));

        doReset("multi_hot", 0);
        idle(eTX());
        applyStimulus(V(1, 0, 9'h003, 9'h000, 0, 2'd0, eEnd(8'h45)));

        doReset("zero_sel", 0);
        idle(eTX());
        applyStimulus(V(1, 0, 9'h000, 9'h000, 0, 2'd0, eEnd(8'h45)));

        doReset("occupied", 0);
        xMoveToCheck(9'h010);
        applyStimulus(V(0, 0, 9'h000, 9'h010, 1, 2'd0, eTO()));
        applyStimulus(V(0, 1, 9'h010, 9'h010, 0, 2'd0, eEnd(8'h45)));
        idle(eEnd(8'h45));
        applyStimulus(V(0, 1, 9'h001, 9'h010, 0, 2'd0, eEnd(8'h45)));
        idle(eEnd(8'h45));

        doReset("cats_with_ignored_button", 0);
        xMoveToCheck(9'h080);
        applyStimulus(V(0, 1, 9'h001, 9'h080, 0, 2'd0, eCheck()));
        applyStimulus(V(0, 0, 9'h000, 9'h080, 1, 2'd1, eEnd(8'h43)));

        doReset("o_wins", 0);
        xMoveToCheck(9'h001);
        applyStimulus(V(0, 0, 9'h000, 9'h001, 1, 2'd2, eEnd(8'h4F)));

        doReset("held_through_reset", 1);
        applyStimulus(V(1, 0, 9'h010, 9'h000, 0, 2'd0, eTX()));
        applyStimulus(V(1, 0, 9'h010, 9'h000, 0, 2'd0, eTX()));
        applyStimulus(V(0, 0, 9'h010, 9'h000, 0, 2'd0, eTX()));
        applyStimulus(V(1, 0, 9'h010, 9'h000, 0, 2'd0, eCommit(9'h010, 1)));

        doReset("reset_mid_check", 0);
        xMoveToCheck(9'h004);
        #2;
        reset = 1'b1;
        #1;
        sb.push_back(eTX());
        checkOutput();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(eTX());
        idle(eTX());

`ifdef TURN_TIMEOUT_EN
        doReset("timeout_x", 0);
        for (int i = 0; i < 7; i++) idle(eTX());
        idle(eEnd(8'h4F));
        idle(eEnd(8'h4F));

        doReset("move_on_last_cycle", 0);
        for (int i = 0; i < 7; i++) idle(eTX());
        applyStimulus(V(1, 0, 9'h010, 9'h000, 0, 2'd0, eCommit(9'h010, 1)));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
